// File: rtl/sar_avg_fifo.sv
// sar_avg_fifo: averages 2^AVG_LOG2 SAR codes with round-half-up and buffers results for valid/ready readout
module sar_avg_fifo #(
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  code_in,
  input  logic        code_strobe,
  input  logic        enable,
  output logic [5:0]  avg_code,
  output logic        avg_valid,
  input  logic        avg_ready,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [15:0] conv_count,
  output logic [4:0]  fifo_level
);
  localparam int CW   = AVG_LOG2 == 0 ? 1 : AVG_LOG2;
  localparam int SW   = 7 + AVG_LOG2;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int HALF = (1 << AVG_LOG2) >> 1;
  typedef enum logic {ACCUM, PUSH} state_t;
  state_t        state;
  logic          strobe_q;
  logic [SW-1:0] sum;
  logic [SW-1:0] tot;
  logic [CW-1:0] cnt;
  logic [5:0]    result;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [PW:0]   wp;
  logic [PW:0]   rp;
  logic [PW:0]   lvl;
  logic          detect;
  logic          last;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          wr;
  assign detect     = code_strobe && !strobe_q && enable;
  assign last       = (AVG_LOG2 == 0) || (&cnt);
  assign tot        = sum + SW'(code_in) + SW'(HALF);
  assign push       = state == PUSH;
  assign lvl        = wp - rp;
  assign empty      = lvl == '0;
  assign full       = lvl == (PW+1)'(FIFO_DEPTH);
  assign pop        = avg_valid && avg_ready;
  assign wr         = push && (!full || pop);
  assign avg_valid  = !empty;
  // gate with empty so the output reads 0 after reset without clearing storage
  assign avg_code   = empty ? '0 : mem[rp[PW-1:0]];
  assign fifo_level = 5'(lvl);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ACCUM;
      strobe_q   <= 1'b0;
      sum        <= '0;
      cnt        <= '0;
      result     <= '0;
      conv_count <= '0;
      wp         <= '0;
      rp         <= '0;
      overflow   <= 1'b0;
    end else begin
      strobe_q <= code_strobe;
      if (push)
        state <= ACCUM;
      if (detect) begin
        conv_count <= conv_count + 16'd1;
        if (last) begin
          result <= 6'(tot >> AVG_LOG2);
          sum    <= '0;
          cnt    <= '0;
          state  <= PUSH;
        end else begin
          sum <= sum + SW'(code_in);
          cnt <= cnt + 1'b1;
        end
      end else if (!enable) begin
        sum <= '0;
        cnt <= '0;
      end
      if (wr)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      overflow <= !clr_ovf && (overflow || (push && !wr));
    end
  always_ff @(posedge clk)
    if (wr)
      mem[wp[PW-1:0]] <= result;
endmodule

// File: doc/sar_avg_fifo.md
# sar_avg_fifo

Downstream consumer of the 6-bit SAR result bus (q5..q0) and its result strobe (rs).
- Detects each completed conversion and averages 2^AVG_LOG2 consecutive codes with round-half-up.
- Buffers the averaged codes in a small FIFO and presents them on a valid/ready interface to the digital readout (wishbone/logic-analyzer side).
- Counts raw conversions and flags dropped results.

## Interface
Parameters:
- AVG_LOG2, default 2: log2 of codes per average; legal 0..4; 0 means pass-through.
- FIFO_DEPTH, default 4: number of averaged-code entries; power of two, 2..16.

Ports:
- clk  input  1  single clock, same clock that drives the SAR controller; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  6  SAR result {q5..q0}; must be stable on the posedge at which the rs rising edge is detected.
- code_strobe  input  1  rs from the SAR; a rising edge marks a new result.
- enable  input  1  high: accept conversions; low: ignore strobes and discard any partial average.
- avg_code  output  6  FIFO head, averaged code.
- avg_valid  output  1  FIFO not empty.
- avg_ready  input  1  consumer accepts the head when avg_valid && avg_ready at posedge.
- overflow  output  1  sticky: an average was dropped because the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.
- conv_count  output  16  wrapping count of accepted raw conversions.
- fifo_level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
Strobe detect:
- strobe_q registers code_strobe every posedge.
- Detect = code_strobe && !strobe_q && enable.
- code_in is sampled on the detect posedge.

Accumulator:
- Width 7+AVG_LOG2.
- Sample counter is AVG_LOG2 bits wide, or 1 bit when AVG_LOG2 = 0.

FSM, two states:
- ACCUM:
  - On detect, add code_in to sum, increment conv_count, increment the sample counter.
  - When the detect carries the 2^AVG_LOG2-th sample, form result = (sum_incl_this + 2^(AVG_LOG2-1)) >> AVG_LOG2. The rounding term is 0 when AVG_LOG2 = 0.
  - Register the result, clear sum and counter, then go to PUSH.
- PUSH, one cycle:
  - Write the result into the FIFO and return to ACCUM.
  - A detect in this cycle is accumulated normally as sample 1 of the next average.

No saturation logic is needed. The maximum of sum + half is 63·2^k + 2^(k-1), which is less than 64·2^k, so the result is always ≤ 63.

FIFO:
- Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits plus a wrap bit.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and the level is unchanged.
  - Otherwise the new entry is dropped, the FIFO contents are unchanged, and overflow sets.
- Pop when empty is ignored.
- Simultaneous push and pop when empty: the push lands, and avg_valid rises on the next cycle.

enable:
- enable low clears sum and counter every cycle; detect is suppressed.
- A pending PUSH still completes.
- The FIFO, conv_count and overflow are unaffected.

overflow:
- clr_ovf wins over a coincident set.

Reset (rst_n low, asynchronous):
- FSM goes to ACCUM.
- sum, counter, pointers and strobe_q go to 0.
- Outputs during reset: avg_code=0, avg_valid=0, overflow=0, conv_count=0, fifo_level=0.
- Reset mid-average discards the partial sum.

## Timing
- Detect posedge N carries the final sample of an average:
  - Result is registered at N.
  - FIFO write happens at N+1.
  - avg_valid and avg_code are visible after N+1, i.e. 2 edges of latency.
- avg_code is driven from FIFO storage indexed by the read pointer. It changes only on a pop or on a write into an empty FIFO.
- Pop at posedge M: the next entry, or avg_valid=0, is visible after M.
- conv_count increments at the detect posedge and wraps from 0xFFFF to 0.
- A strobe held high for multiple cycles counts once. It must return low for at least one posedge before the next detect.
- Maximum sustained input rate is one detect per 2 cycles, which the SAR's 9-cycle conversion guarantees.

## Test plan
- Averaging, AVG_LOG2=2:
  - Strobe codes 10, 11, 12, 13 → avg_code=12, avg_valid after 2 edges past the 4th detect, conv_count=4.
  - Strobe codes 0, 0, 0, 2 → avg_code=1 (rounding).
  - Strobe 63 ×4 → avg_code=63.
- Pass-through, AVG_LOG2=0: codes 5, 40, 63 with avg_ready=1 → avg_code sequence 5, 40, 63, each for one cycle; fifo_level never exceeds 1.
- Full and overflow, FIFO_DEPTH=4, avg_ready=0:
  - 5 averages → fifo_level=4, overflow=1, fifo_level stays 4, and the 4 retained entries are the first 4 in order.
  - clr_ovf → overflow=0.
  - Full FIFO with push coinciding with a pop → overflow stays 0, level stays 4.
- enable and strobe hold:
  - Feed 2 codes, drop enable for 1 cycle, feed 4 codes of 20 → single avg_code=20; conv_count=6.
  - Strobe held high 5 cycles → conv_count +1 only.
- Reset mid-operation:
  - Assert rst_n low after 3 of 4 samples with 2 FIFO entries held → all outputs 0 immediately, without a clock.
  - After release, 4 codes of 7 → avg_code=7.
- Pointer wrap: stream 20 averages with random avg_ready → output order and values match a reference model, with no loss while the level stays below 4.
